wb_arbiter_2m: RTL and testbench

Two-master Wishbone arbiter sharing the single SoC interconnect master port (into `wb_intercon`) between the core data-bus controller (m0) and a second bus master (m1: boot loader / DMA). It:

- grants whole bus cycles (held for the full `cyc` duration) using round-robin priority;
- inserts a one-cycle turnaround between owners;
- terminates hung transfers with a bus-error after a programmable timeout.

---
 rtl/wb_arb_pkg.sv | 7 +
 rtl/wb_timeout_counter.sv | 19 +
 rtl/wb_arbiter_2m.sv | 96 +++++++++
 tb/tb_wb_arbiter_2m.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the two-master Wishbone arbiter.
// Contents: arb_state_t arbiter FSM encoding, classic-cycle CTI and linear BTE constants.
package wb_arb_pkg;
   typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} arb_state_t;
   localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
   localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
endpackage

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: counts stalled strobe cycles and flags expiry at LIMIT.
// Ports: clk, rst (sync, active-high); en = stalled cycle; clr = restart count;
// expire = this stalled cycle is the LIMIT-th in a row (count restarts).
module wb_timeout_counter #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expire
);
   logic [15:0] r_cnt;
   // r_cnt holds the stalled cycles already seen, so the LIMIT-th one sees LIMIT-1
   assign expire = en & (r_cnt == 16'(LIMIT - 1));
   always_ff @(posedge clk)
      if (rst || clr || expire) r_cnt <= '0;
      else if (en) r_cnt <= r_cnt + 16'd1;
endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: round-robin two-master Wishbone arbiter with turnaround and transfer timeout.
// Ports: wb_clk_i/wb_rst_i clock and sync reset; m0_*/m1_* master buses; s_* interconnect port;
// grant_o one-hot owner; timeout_o one-cycle pulse when a hung transfer is errored.
module wb_arbiter_2m
   import wb_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_we_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_we_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   output logic        s_we_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic [2:0]  s_cti_o,
   output logic [1:0]  s_bte_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_err_i,
   output logic [1:0]  grant_o,
   output logic        timeout_o
);
   arb_state_t r_state, w_next;
   logic r_last;
   logic w_own0, w_own1, w_stb, w_en, w_expire;
   assign w_own0 = r_state == OWN0;
   assign w_own1 = r_state == OWN1;
   // stb only counts while the owner still holds cyc, so dropping cyc never raises a timeout
   assign w_stb = w_own0 ? m0_cyc_i & m0_stb_i : w_own1 ? m1_cyc_i & m1_stb_i : 1'b0;
   assign w_en = w_stb & ~s_ack_i & ~s_err_i;
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign s_cti_o = WB_CTI_CLASSIC;
   assign s_bte_o = WB_BTE_LINEAR;
   wb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
      .clk(wb_clk_i),
      .rst(wb_rst_i),
      .en(w_en),
      .clr(~w_en),
      .expire(w_expire)
   );
   // r_last: 0 = m0 owned last, 1 = m1 owned last (reset value lets m0 win the first tie)
   always_ff @(posedge wb_clk_i)
      if (wb_rst_i) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_next;
         if (w_own0 && !m0_cyc_i) r_last <= 1'b0;
         if (w_own1 && !m1_cyc_i) r_last <= 1'b1;
      end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = (m0_cyc_i && m1_cyc_i) ? (r_last ? OWN0 : OWN1) :
                           m0_cyc_i ? OWN0 : m1_cyc_i ? OWN1 : IDLE;
         OWN0:    w_next = m0_cyc_i ? OWN0 : TURN;
         OWN1:    w_next = m1_cyc_i ? OWN1 : TURN;
         default: w_next = IDLE;
      endcase
   end
   always_comb begin
      s_adr_o   = w_own0 ? m0_adr_i : w_own1 ? m1_adr_i : '0;
      s_dat_o   = w_own0 ? m0_dat_i : w_own1 ? m1_dat_i : '0;
      s_sel_o   = w_own0 ? m0_sel_i : w_own1 ? m1_sel_i : '0;
      s_we_o    = w_own0 ? m0_we_i : w_own1 ? m1_we_i : 1'b0;
      s_cyc_o   = w_own0 ? m0_cyc_i : w_own1 ? m1_cyc_i : 1'b0;
      s_stb_o   = w_stb & ~w_expire;
      m0_ack_o  = w_own0 & s_ack_i;
      m1_ack_o  = w_own1 & s_ack_i;
      m0_err_o  = w_own0 & (s_err_i | w_expire);
      m1_err_o  = w_own1 & (s_err_i | w_expire);
      grant_o   = {w_own1, w_own0};
      timeout_o = w_expire;
   end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed self-checking bench for wb_arbiter_2m with a 4-cycle timeout.
module tb_wb_arbiter_2m;
   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] m0_adr = '0, m0_dat = '0, m1_adr = '0, m1_dat = '0, s_dat_i = '0;
   logic [3:0]  m0_sel = '0, m1_sel = '0;
   logic        m0_we = 1'b0, m0_cyc = 1'b0, m0_stb = 1'b0;
   logic        m1_we = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0;
   logic        s_ack_i = 1'b0, s_err_i = 1'b0;
   logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
   logic [3:0]  s_sel_o;
   logic [2:0]  s_cti_o;
   logic [1:0]  s_bte_o, grant_o;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic        s_we_o, s_cyc_o, s_stb_o, timeout_o;
   int n_chk = 0, n_fail = 0;

   wb_arbiter_2m #(.TIMEOUT_CYCLES(4)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_grant", 32'(grant_o), 32'h0);
      chk("rst_cyc", 32'(s_cyc_o), 32'h0);
      chk("rst_stb", 32'(s_stb_o), 32'h0);
      chk("rst_adr", s_adr_o, 32'h0);
      chk("rst_cti_bte", 32'({s_cti_o, s_bte_o}), 32'h0);
      // tie straight after reset: m0 read, m1 write both request
      m0_adr = 32'h0000_0010; m0_sel = 4'hf; m0_cyc = 1'b1; m0_stb = 1'b1;
      m1_adr = 32'h0000_0200; m1_dat = 32'hDEAD_BEEF; m1_sel = 4'b1100; m1_we = 1'b1;
      m1_cyc = 1'b1; m1_stb = 1'b1;
      #1;
      chk("lat_cyc_idle", 32'(s_cyc_o), 32'h0);
      tick();
      chk("tie0_grant", 32'(grant_o), 32'h1);
      chk("tie0_cyc", 32'(s_cyc_o), 32'h1);
      chk("tie0_adr", s_adr_o, 32'h0000_0010);
      chk("tie0_stb", 32'(s_stb_o), 32'h1);
      tick();
      tick();
      tick();
      // ack lands in the 4th stalled cycle: ack must win over the timeout
      s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
      #1;
      chk("rd_m0_ack", 32'(m0_ack_o), 32'h1);
      chk("rd_m0_dat", m0_dat_o, 32'hCAFE_F00D);
      chk("rd_m1_ack", 32'(m1_ack_o), 32'h0);
      chk("race_err", 32'(m0_err_o), 32'h0);
      chk("race_tmo", 32'(timeout_o), 32'h0);
      tick();
      s_ack_i = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      #1;
      chk("drop_cyc", 32'(s_cyc_o), 32'h0);
      chk("drop_grant", 32'(grant_o), 32'h1);
      tick();
      m0_cyc = 1'b1; m0_stb = 1'b1;
      #1;
      chk("turn_grant", 32'(grant_o), 32'h0);
      chk("turn_stb", 32'(s_stb_o), 32'h0);
      tick();
      #1;
      chk("idle_grant", 32'(grant_o), 32'h0);
      tick();
      // tie again: m0 owned last, so m1 wins
      chk("rr_grant", 32'(grant_o), 32'h2);
      chk("m1_dat", s_dat_o, 32'hDEAD_BEEF);
      chk("m1_sel", 32'(s_sel_o), 32'hC);
      chk("m1_we", 32'(s_we_o), 32'h1);
      chk("m1_adr", s_adr_o, 32'h0000_0200);
      s_ack_i = 1'b1;
      #1;
      chk("wr_m1_ack", 32'(m1_ack_o), 32'h1);
      chk("wr_m0_ack", 32'(m0_ack_o), 32'h0);
      tick();
      s_ack_i = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
      tick();
      tick();
      tick();
      // m0 owns again; slave stalls, m1 waits
      chk("own0_grant", 32'(grant_o), 32'h1);
      m1_adr = 32'h0000_0300; m1_cyc = 1'b1; m1_stb = 1'b1;
      tick();
      tick();
      #1;
      chk("pre_tmo", 32'(timeout_o), 32'h0);
      tick();
      chk("tmo_pulse", 32'(timeout_o), 32'h1);
      chk("tmo_err", 32'(m0_err_o), 32'h1);
      chk("tmo_stb", 32'(s_stb_o), 32'h0);
      chk("tmo_cyc", 32'(s_cyc_o), 32'h1);
      chk("tmo_m1_err", 32'(m1_err_o), 32'h0);
      chk("tmo_m1_ack", 32'(m1_ack_o), 32'h0);
      tick();
      chk("post_tmo", 32'(timeout_o), 32'h0);
      chk("post_stb", 32'(s_stb_o), 32'h1);
      chk("post_grant", 32'(grant_o), 32'h1);
      tick();
      tick();
      tick();
      // slave error in the would-be timeout cycle: error passes, no timeout pulse
      s_err_i = 1'b1;
      #1;
      chk("serr_err", 32'(m0_err_o), 32'h1);
      chk("serr_tmo", 32'(timeout_o), 32'h0);
      chk("serr_stb", 32'(s_stb_o), 32'h1);
      tick();
      s_err_i = 1'b0; m0_cyc = 1'b0;
      #1;
      chk("abort_err", 32'(m0_err_o), 32'h0);
      chk("abort_stb", 32'(s_stb_o), 32'h0);
      tick();
      tick();
      tick();
      chk("own1_grant", 32'(grant_o), 32'h2);
      chk("own1_adr", s_adr_o, 32'h0000_0300);
      // reset while m1 owns; m0 also requesting
      rst = 1'b1; m0_cyc = 1'b1; m0_stb = 1'b1;
      tick();
      chk("mrst_grant", 32'(grant_o), 32'h0);
      chk("mrst_cyc", 32'(s_cyc_o), 32'h0);
      chk("mrst_adr", s_adr_o, 32'h0);
      rst = 1'b0;
      tick();
      chk("mrst_tie", 32'(grant_o), 32'h1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
